// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the mem_responder memory-side handshake block.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    // Forces the low address bits an access size cannot use down to zero.
    function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return off;
            SZ_HALF: return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: merges store data into a word and extracts/extends load data.
module mem_lane_align
    import mem_responder_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    output logic [31:0] wr_word,
    output logic [31:0] rd_data
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign byte_sh = {off, 3'b000};
    assign half_sh = {off[1], 4'b0000};

    always_comb begin
        wr_word = old_word;
        rd_data = '0;
        lane_b  = old_word[byte_sh +: 8];
        lane_h  = old_word[half_sh +: 16];
        case (size)
            SZ_BYTE: begin
                wr_word[byte_sh +: 8] = wdata[7:0];
                rd_data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            end
            SZ_HALF: begin
                wr_word[half_sh +: 16] = wdata[15:0];
                rd_data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            end
            default: begin
                wr_word = wdata;
                rd_data = old_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding RAM responder with LATENCY wait states and a one-cycle rsp_valid.
// Optional MEM_RESPONDER_ALIGN_CHK_EN: misaligned accesses complete with rsp_err instead of aligning down.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        busy,
    output logic        rsp_valid,
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    output logic        rsp_err,
`endif
    output logic [31:0] rsp_rdata
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY > 0 ? LATENCY - 1 : 0);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        busy_q, busy_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        err_q, err_d;

    logic        accept, enter_resp, mis, do_write;
    logic        sel_wr, sel_uns;
    logic [31:0] sel_addr, sel_wdata;
    logic [1:0]  sel_size, off;
    logic [AW-1:0] idx;
    logic [31:0] old_word, wr_word, rd_data;
    logic        unused_addr_hi;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept = (state_q == IDLE) && (req_rd || req_wr);

    // With zero wait states the RAM access happens on the accepting edge, so it uses the live request.
    assign sel_wr    = (state_q == IDLE) ? req_wr       : wr_q;
    assign sel_addr  = (state_q == IDLE) ? req_addr     : addr_q;
    assign sel_wdata = (state_q == IDLE) ? req_wdata    : wdata_q;
    assign sel_size  = (state_q == IDLE) ? req_size     : size_q;
    assign sel_uns   = (state_q == IDLE) ? req_unsigned : uns_q;

    assign idx            = sel_addr[AW+1:2];
    assign off            = align_off(sel_size, sel_addr[1:0]);
    assign old_word       = mem[idx];
    assign unused_addr_hi = ^sel_addr[31:AW+2];

`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    assign mis = is_misaligned(sel_size, sel_addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    assign enter_resp = (LATENCY == 0) ? accept : ((state_q == WAIT) && (cnt_q == 4'd0));
    assign do_write   = enter_resp && sel_wr && !mis;

    mem_lane_align u_lane (
        .old_word    (old_word),
        .wdata       (sel_wdata),
        .size        (sel_size),
        .off         (off),
        .is_unsigned (sel_uns),
        .wr_word     (wr_word),
        .rd_data     (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        uns_d       = uns_q;
        rsp_rdata_d = rsp_rdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            rsp_rdata_d = (sel_wr || mis) ? 32'd0 : rd_data;
            err_d       = mis;
        end
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        wr_q    <= wr_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        size_q  <= size_d;
        uns_q   <= uns_d;
        if (do_write && !rst) mem[idx] <= wr_word;
    end

    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    assign rsp_err   = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a word-array reference model (LATENCY=2 and LATENCY=0 instances).
module tb_mem_responder;

    localparam int LAT = 2;
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_rd, req_wr, req_unsigned, busy, rsp_valid;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0]  req_size;
    logic        z_rd, z_wr, z_uns, z_busy, z_valid;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic [1:0]  z_size;
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    logic        rsp_err, z_err;
`endif

    int checks = 0;
    int failures = 0;
    logic [31:0] model [256];

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .busy(busy), .rsp_valid(rsp_valid),
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
        .rsp_err(rsp_err),
`endif
        .rsp_rdata(rsp_rdata)
    );

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_rd(z_rd), .req_wr(z_wr), .req_addr(z_addr),
        .req_wdata(z_wdata), .req_size(z_size), .req_unsigned(z_uns),
        .busy(z_busy), .rsp_valid(z_valid),
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
        .rsp_err(z_err),
`endif
        .rsp_rdata(z_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int m_off(input logic [1:0] size, input logic [1:0] a);
        if (size == 2'd0) return int'(a);
        if (size == 2'd1) return int'(a) & 2;
        return 0;
    endfunction

    function automatic bit m_mis(input logic [1:0] size, input logic [1:0] a);
        return (size == 2'd1 && a[0]) || (size >= 2'd2 && a != 2'd0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] size,
                                           input logic [1:0] a, input logic uns);
        logic [31:0] v;
        int sh;
        sh = 8 * m_off(size, a);
        if (size == 2'd0) begin
            v = (w >> sh) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (size == 2'd1) begin
            v = (w >> sh) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] size, input logic [1:0] a);
        logic [31:0] mask;
        int sh;
        sh = 8 * m_off(size, a);
        if (size == 2'd0)      mask = 32'hFF << sh;
        else if (size == 2'd1) mask = 32'hFFFF << sh;
        else                   mask = 32'hFFFFFFFF;
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic xact(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        input bit poke, input string tag, output logic [31:0] got);
        logic [31:0] exp_rd;
        bit mis;
        int idx, cyc, bcnt;
        idx = int'((addr >> 2) % 256);
        mis = CHK_EN && m_mis(size, addr[1:0]);
        if (wr || mis) exp_rd = 32'd0;
        else           exp_rd = m_load(model[idx], size, addr[1:0], uns);
        if (wr && !mis) model[idx] = m_store(model[idx], wdata, size, addr[1:0]);

        @(negedge clk);
        req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        @(posedge clk); #1;
        req_rd = 1'b0; req_wr = 1'b0;
        cyc = 1; bcnt = 0;
        while (!rsp_valid && cyc <= LAT + 5) begin
            if (busy) bcnt++;
            if (poke && cyc == 1) req_rd = 1'b1;
            @(posedge clk); #1;
            req_rd = 1'b0;
            cyc++;
        end
        if (busy) bcnt++;
        got = rsp_rdata;
        check({tag, ".latency"}, cyc, LAT + 1);
        check({tag, ".busy_cycles"}, bcnt, LAT + 1);
        check({tag, ".rdata"}, rsp_rdata, exp_rd);
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
        check({tag, ".err"}, {31'd0, rsp_err}, {31'd0, mis});
`endif
        @(posedge clk); #1;
        check({tag, ".valid_drop"}, {30'd0, rsp_valid, busy}, 32'd0);
        check({tag, ".rdata_hold"}, rsp_rdata, exp_rd);
        if (poke) begin
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                check({tag, ".no_extra_rsp"}, {31'd0, rsp_valid}, 32'd0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] got, a, d;
        logic rd, wr;
        rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_unsigned = 1'b0;
        z_rd = 1'b0; z_wr = 1'b0; z_addr = '0; z_wdata = '0; z_size = 2'd0; z_uns = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.valid", {31'd0, rsp_valid}, 32'd0);
        check("reset.rdata", rsp_rdata, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 64; i++) xact(1'b0, 1'b1, i * 4, $urandom, 2'd2, 1'b0, 1'b0, "prefill", got);

        xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, "sw10", got);
        xact(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0, "lw10", got);
        check("lw10.const", got, 32'hDEADBEEF);
        xact(1'b1, 1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 1'b0, "lb13", got);
        check("lb13.const", got, 32'hFFFFFFDE);
        xact(1'b1, 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 1'b0, "lbu13", got);
        check("lbu13.const", got, 32'h000000DE);
        xact(1'b1, 1'b0, 32'h10, 32'h0, 2'd1, 1'b0, 1'b0, "lh10", got);
        check("lh10.const", got, 32'hFFFFBEEF);
        xact(1'b1, 1'b0, 32'h12, 32'h0, 2'd1, 1'b1, 1'b0, "lhu12", got);
        check("lhu12.const", got, 32'h0000DEAD);
        xact(1'b0, 1'b1, 32'h11, 32'h55, 2'd0, 1'b0, 1'b0, "sb11", got);
        xact(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b1, "lw10_poke", got);
        check("lw10_poke.const", got, 32'hDEAD55EF);
        xact(1'b1, 1'b1, 32'h14, 32'h0BADF00D, 2'd2, 1'b0, 1'b0, "rdwr14", got);

        // Abort a store while it is still counting wait states.
        xact(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0, "pre_abort", got);
        @(negedge clk);
        req_wr = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_size = 2'd2;
        @(posedge clk); #1;
        req_wr = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("abort.busy", {31'd0, busy}, 32'd0);
        check("abort.valid", {31'd0, rsp_valid}, 32'd0);
        check("abort.rdata", rsp_rdata, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("abort.no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        xact(1'b1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 1'b0, "lw20_after_abort", got);

        xact(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 2'd2, 1'b0, 1'b0, "sw400", got);
        xact(1'b1, 1'b0, 32'h000, 32'h0, 2'd2, 1'b0, 1'b0, "lw0_wrap", got);
        check("lw0_wrap.const", got, 32'hCAFEF00D);

        xact(1'b0, 1'b1, 32'h22, 32'h77665544, 2'd2, 1'b0, 1'b0, "sw22_mis", got);
        xact(1'b1, 1'b0, 32'h23, 32'h0, 2'd2, 1'b0, 1'b0, "lw23_mis", got);
        xact(1'b1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 1'b0, "lw20", got);
        xact(1'b1, 1'b0, 32'h21, 32'h0, 2'd1, 1'b0, 1'b0, "lh21_mis", got);

        for (int n = 0; n < 200; n++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 3) << 10);
            d = $urandom;
            xact(rd, wr, a, d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), "rand", got);
        end

        // Zero-wait-state instance: response lands on the cycle right after acceptance.
        @(negedge clk);
        z_wr = 1'b1; z_addr = 32'h8; z_wdata = 32'hA5A55A5A; z_size = 2'd2;
        @(posedge clk); #1;
        z_wr = 1'b0;
        check("lat0.sw.valid", {30'd0, z_valid, z_busy}, 32'd3);
        check("lat0.sw.rdata", z_rdata, 32'd0);
        @(posedge clk); #1;
        check("lat0.sw.idle", {30'd0, z_valid, z_busy}, 32'd0);
        @(negedge clk);
        z_rd = 1'b1; z_addr = 32'h8; z_size = 2'd2;
        @(posedge clk); #1;
        z_rd = 1'b0;
        check("lat0.lw.valid", {31'd0, z_valid}, 32'd1);
        check("lat0.lw.rdata", z_rdata, 32'hA5A55A5A);
        @(negedge clk);
        z_rd = 1'b1; z_addr = 32'hB; z_size = 2'd0; z_uns = 1'b1;
        @(posedge clk); #1;
        z_rd = 1'b0;
        check("lat0.lbu.valid", {31'd0, z_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat0.lbu.valid2", {31'd0, z_valid}, 32'd0);
        @(negedge clk);
        z_rd = 1'b1;
        @(posedge clk); #1;
        z_rd = 1'b0;
        check("lat0.lbu.rdata", z_rdata, 32'h000000A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
